// File: rtl/freq_mult_pkg.sv
// -----------------------------------------------------------------------------
// freq_mult_pkg
//   Shared types and helpers for the Freq_Mult scheduling logic.
//   - state_t     : scheduler FSM state encoding (3 bits)
//   - VI_W_DEF    : default vi operand width
//   - UI_W_DEF    : default ui operand width
//   - pick_t      : result of a round-robin pick (valid + index)
//   - rr_next()   : round-robin search over up to 8 requesters
// -----------------------------------------------------------------------------
package freq_mult_pkg;

   localparam int STATE_W  = 3;
   localparam int VI_W_DEF = 16;
   localparam int UI_W_DEF = 2;
   localparam int RR_MAX   = 8;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      WAIT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [2:0] idx;
   } pick_t;

   // First set bit of req at or after ptr, wrapping modulo n (2..8).
   function automatic pick_t rr_next(input logic [RR_MAX-1:0] req,
                                     input logic [2:0]        ptr,
                                     input int unsigned       n = RR_MAX);
      pick_t       r;
      int unsigned j;
      r = '0;
      for (int unsigned k = 0; k < RR_MAX; k++) begin
         j = (32'(ptr) + k) % n;
         if (!r.valid && (k < n) && req[j]) begin
            r.valid = 1'b1;
            r.idx   = 3'(j);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Returns the first asserted request at or
//   after ptr, wrapping around N_REQ entries.
//   Parameters: N_REQ (2..8)
//   Ports:
//     req    in  N_REQ          request vector
//     ptr    in  $clog2(N_REQ)  highest-priority position
//     valid  out 1              at least one request asserted
//     idx    out $clog2(N_REQ)  index of the selected requester
// -----------------------------------------------------------------------------
module rr_pick
   import freq_mult_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic                     valid,
   output logic [$clog2(N_REQ)-1:0] idx
);

   localparam int IW = $clog2(N_REQ);

   pick_t p;

   always_comb begin
      p     = rr_next(RR_MAX'(req), 3'(ptr), N_REQ);
      valid = p.valid;
      idx   = IW'(p.idx);
   end

endmodule

// File: rtl/freq_mult_sched.sv
// -----------------------------------------------------------------------------
// freq_mult_sched
//   Round-robin scheduler sharing one Freq_Mult datapath between N_REQ
//   requesters. The winner's operands are latched in IDLE, presented for one
//   LOAD cycle, started with a one-cycle fm_start pulse, and the winner is
//   acked one cycle after the rising edge of fm_done.
//
//   Build option: define FMS_TIMEOUT_EN to enable a WAIT watchdog of
//   TIMEOUT_CYC cycles; on expiry err is set and the ack is still issued.
//   Without it err is tied low and WAIT lasts until a done edge.
//
//   Parameters: N_REQ (2..8), VI_W, UI_W, TIMEOUT_CYC
//   Ports:
//     clk       in   1              system clock, rising edge
//     rst       in   1              asynchronous reset, active-high
//     req       in   N_REQ          request per requester, held until ack
//     req_vi    in   N_REQ*VI_W     packed vi operands
//     req_ui    in   N_REQ*UI_W     packed ui operands
//     ack       out  N_REQ          one-cycle completion pulse
//     grant_id  out  $clog2(N_REQ)  current/last granted requester
//     busy      out  1              high in every state except IDLE
//     err       out  1              watchdog flag, sticky until next grant
//     fm_vi     out  VI_W           registered vi to Freq_Mult
//     fm_ui     out  UI_W           registered ui to Freq_Mult
//     fm_start  out  1              one-cycle start pulse
//     fm_done   in   1              done from Freq_Mult
// -----------------------------------------------------------------------------
module freq_mult_sched
   import freq_mult_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int VI_W        = VI_W_DEF,
   parameter int UI_W        = UI_W_DEF,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*VI_W-1:0]    req_vi,
   input  logic [N_REQ*UI_W-1:0]    req_ui,
   output logic [N_REQ-1:0]         ack,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     busy,
   output logic                     err,
   output logic [VI_W-1:0]          fm_vi,
   output logic [UI_W-1:0]          fm_ui,
   output logic                     fm_start,
   input  logic                     fm_done
);

   localparam int IW = $clog2(N_REQ);

   state_t          state;
   logic [IW-1:0]   rr_ptr;
   logic            done_q;
   logic            done_rise;
   logic            pick_valid;
   logic [IW-1:0]   pick_idx;
   logic [IW-1:0]   next_ptr;

`ifdef FMS_TIMEOUT_EN
   localparam int            CW   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYC - 1);
   logic [CW-1:0] wait_cnt;
   logic          err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .req   (req),
      .ptr   (rr_ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // A level-high done left over from a previous operation must not complete
   // the current one, so only a 0->1 transition counts.
   assign done_rise = fm_done & ~done_q;

   assign next_ptr = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         ack      <= '0;
         fm_start <= 1'b0;
         fm_vi    <= '0;
         fm_ui    <= '0;
         busy     <= 1'b0;
         done_q   <= 1'b0;
`ifdef FMS_TIMEOUT_EN
         wait_cnt <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         done_q   <= fm_done;
         ack      <= '0;
         fm_start <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  grant_id <= pick_idx;
                  fm_vi    <= req_vi[pick_idx*VI_W +: VI_W];
                  fm_ui    <= req_ui[pick_idx*UI_W +: UI_W];
                  busy     <= 1'b1;
                  state    <= LOAD;
`ifdef FMS_TIMEOUT_EN
                  err_q    <= 1'b0;
`endif
               end
            end
            LOAD: begin
               // fm_start is registered, so it is raised here to be high
               // during the START cycle.
               fm_start <= 1'b1;
               state    <= START;
            end
            START: begin
`ifdef FMS_TIMEOUT_EN
               wait_cnt <= '0;
`endif
               state <= WAIT;
            end
            WAIT: begin
               // ack is registered: raising it on the WAIT->DONE transition
               // makes it high for exactly the DONE cycle.
               if (done_rise) begin
                  ack   <= N_REQ'(1) << grant_id;
                  state <= DONE;
               end
`ifdef FMS_TIMEOUT_EN
               else if (wait_cnt == TLIM) begin
                  err_q <= 1'b1;
                  ack   <= N_REQ'(1) << grant_id;
                  state <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            DONE: begin
               rr_ptr <= next_ptr;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_freq_mult_sched.sv
module tb_freq_mult_sched;

   localparam int N  = 4;
   localparam int VW = 16;
   localparam int UW = 2;
   localparam int TO = 16;

   typedef struct {
      int         idx;
      logic [15:0] vi;
      logic [1:0]  ui;
      bit          e_err;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req = '0;
   logic [15:0]    opv [N];
   logic [1:0]     opu [N];
   logic [N*VW-1:0] req_vi;
   logic [N*UW-1:0] req_ui;
   logic [N-1:0]   ack;
   logic [1:0]     grant_id;
   logic           busy, err;
   logic [VW-1:0]  fm_vi;
   logic [UW-1:0]  fm_ui;
   logic           fm_start;
   logic           fm_done = 1'b0;

   int checks = 0;
   int failures = 0;

   exp_t sb[$];
   int   rem [N];
   int   mptr = 0;
   bit   dp_mode = 0;
   bit   dp_manual = 0;
   int   dp_cnt = 0;

   assign req_vi = {opv[3], opv[2], opv[1], opv[0]};
   assign req_ui = {opu[3], opu[2], opu[1], opu[0]};

   freq_mult_sched #(
      .N_REQ       (N),
      .VI_W        (VW),
      .UI_W        (UW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_vi   (req_vi),
      .req_ui   (req_ui),
      .ack      (ack),
      .grant_id (grant_id),
      .busy     (busy),
      .err      (err),
      .fm_vi    (fm_vi),
      .fm_ui    (fm_ui),
      .fm_start (fm_start),
      .fm_done  (fm_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
      checks++;
      if (act !== req_v) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
      end
   endtask

   // Monitor: compares DUT presentations against the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (fm_start) begin
            if (sb.size() == 0) chk("start_unexpected", 64'd1, 64'd0);
            else begin
               chk("grant_id", 64'(grant_id), 64'(sb[0].idx));
               chk("fm_vi",    64'(fm_vi),    64'(sb[0].vi));
               chk("fm_ui",    64'(fm_ui),    64'(sb[0].ui));
               chk("err_at_start", 64'(err),  64'd0);
               chk("busy_at_start", 64'(busy), 64'd1);
            end
         end
         if (ack != '0) begin
            chk("ack_onehot", 64'($countones(ack)), 64'd1);
            if (sb.size() == 0) chk("ack_unexpected", 64'(ack), 64'd0);
            else begin
               chk("ack_vec", 64'(ack), 64'(4'b0001 << sb[0].idx));
               chk("err_at_ack", 64'(err), 64'(sb[0].e_err));
               void'(sb.pop_front());
            end
         end
      end
   end

   // One cycle of stimulus: requester behaviour and Freq_Mult datapath model.
   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (ack[i] && rem[i] > 0) begin
            rem[i]--;
            if (rem[i] == 0) req[i] = 1'b0;
         end
      end
      // Operands of a requester on its last service change after grant;
      // the latched values must not follow.
      if (fm_start && rem[grant_id] == 1) opv[grant_id] = 16'($urandom);
      if (dp_mode) fm_done = dp_manual;
      else if (fm_start) begin
         dp_cnt  = $urandom_range(1, 6);
         fm_done = 1'b0;
      end else if (dp_cnt > 0) begin
         dp_cnt--;
         fm_done = (dp_cnt == 0);
      end else fm_done = 1'b0;
   endtask

   function automatic int first_at(input int pend[N], input int ptr);
      for (int k = 0; k < N; k++)
         if (pend[(ptr + k) % N] > 0) return (ptr + k) % N;
      return -1;
   endfunction

   // Raise a set of requests (each served cnt times) and queue the expected
   // service order from the round-robin rule.
   task automatic issue(input logic [N-1:0] set, input int cnt, input bit e_err,
                        input bit fixed, input logic [15:0] fvi, input logic [1:0] fui);
      int pend [N];
      int j;
      exp_t e;
      for (int i = 0; i < N; i++) begin
         pend[i] = 0;
         if (set[i]) begin
            rem[i]  = cnt;
            pend[i] = cnt;
            opv[i]  = fixed ? fvi : 16'($urandom);
            opu[i]  = fixed ? fui : 2'($urandom);
            req[i]  = 1'b1;
         end
      end
      j = first_at(pend, mptr);
      while (j >= 0) begin
         e.idx = j; e.vi = opv[j]; e.ui = opu[j]; e.e_err = e_err;
         sb.push_back(e);
         pend[j]--;
         mptr = (j + 1) % N;
         j = first_at(pend, mptr);
      end
   endtask

   task automatic drain(input string name, input int exp_starts);
      int starts = 0;
      int n = 0;
      while (sb.size() != 0 && n < 3000) begin
         tick();
         if (fm_start) starts++;
         n++;
      end
      chk({name, "_drained"}, 64'(sb.size()), 64'd0);
      chk({name, "_starts"}, 64'(starts), 64'(exp_starts));
   endtask

   task automatic wait_start(input string name);
      int n = 0;
      while (!fm_start && n < 200) begin tick(); n++; end
      chk({name, "_start_seen"}, 64'(fm_start), 64'd1);
   endtask

   initial begin
      int n;
      int lat;
      int acks;
      for (int i = 0; i < N; i++) begin opv[i] = '0; opu[i] = '0; rem[i] = 0; end

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1 chk("reset_outputs", 64'({ack, fm_start, fm_vi, fm_ui, busy, err, grant_id}), 64'd0);

      // 1: single requester, fixed operands, latency to fm_start
      tick();
      issue(4'b0001, 1, 0, 1, 16'hC000, 2'b10);
      lat = 0;
      while (!fm_start && lat < 20) begin tick(); lat++; end
      chk("req_to_start_latency", 64'(lat), 64'd2);
      drain("single", 0);

      // 2: simultaneous requests after reset (rr_ptr=0)
      rst = 1'b1; tick(); rst = 1'b0; mptr = 0; tick();
      issue(4'b1010, 1, 0, 0, '0, '0);
      drain("simul", 2);

      // 3: fairness, req[0] and req[2] held for three services each
      tick();
      issue(4'b0101, 3, 0, 0, '0, '0);
      drain("fair", 6);

      // Randomized batches
      for (int b = 0; b < 25; b++) begin
         logic [N-1:0] s;
         s = 4'($urandom_range(1, 15));
         repeat ($urandom_range(0, 3)) tick();
         issue(s, $urandom_range(1, 3), 0, 0, '0, '0);
         drain("rand", $countones(s) * rem[first_at('{rem[0], rem[1], rem[2], rem[3]}, 0)] * 0 + sb.size());
      end

      // 4: stale done held high across a new grant (requester 1 -> ptr 2)
      tick();
      dp_mode = 1; dp_manual = 1;
      tick(); tick();
      issue(4'b0010, 1, 0, 0, '0, '0);
      wait_start("stale");
      acks = 0;
      repeat (6) begin tick(); if (ack != '0) acks++; end
      chk("stale_no_ack", 64'(acks), 64'd0);
      dp_manual = 0; tick();
      dp_manual = 1; tick();
      tick();
      chk("stale_ack_after_edge", 64'(ack), 64'b0010);
      dp_manual = 0; dp_mode = 0;
      tick();

      // 5: reset while waiting on the datapath
      dp_mode = 1; dp_manual = 0;
      issue(4'b0010, 1, 0, 0, '0, '0);
      wait_start("rst_wait");
      tick(); tick();
      rst = 1'b1;
      #1 chk("reset_in_wait", 64'({ack, fm_start, fm_vi, fm_ui, busy, err, grant_id}), 64'd0);
      sb.delete();
      req = '0;
      for (int i = 0; i < N; i++) rem[i] = 0;
      mptr = 0;
      tick(); tick();
      rst = 1'b0; dp_mode = 0;
      tick();
      chk("idle_after_reset", 64'(busy), 64'd0);
      issue(4'b1010, 1, 0, 0, '0, '0);
      drain("post_reset", 2);

`ifdef FMS_TIMEOUT_EN
      // 6: watchdog with fm_done stuck low
      dp_mode = 1; dp_manual = 0;
      issue(4'b1000, 1, 1, 0, '0, '0);
      wait_start("timeout");
      n = 0;
      while (ack == '0 && n < 100) begin tick(); n++; end
      chk("timeout_cycles", 64'(n), 64'(TO + 1));
      chk("timeout_err", 64'(err), 64'd1);
      dp_mode = 0;
      tick();
      issue(4'b0001, 1, 0, 0, '0, '0);
      drain("after_timeout", 1);
`else
      chk("err_tied_low", 64'(err), 64'd0);
`endif

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
